// File: rtl/gerador_trigger_hcsr04_if.sv
// Signal bundle between the HC-SR04 trigger generator and its user/sensor side.
// The slave modport is the generator; master is the requester/sensor model.
interface gerador_trigger_hcsr04_if;
    logic       gera;
    logic       echo;
    logic       trigger;
    logic       ocupado;
    logic       pronto;
    logic       timeout;
    logic [2:0] db_estado;

    modport slave (
        input  gera,
        input  echo,
        output trigger,
        output ocupado,
        output pronto,
        output timeout,
        output db_estado
    );

    modport master (
        output gera,
        output echo,
        input  trigger,
        input  ocupado,
        input  pronto,
        input  timeout,
        input  db_estado
    );
endinterface

// File: rtl/gerador_trigger_hcsr04.sv
// HC-SR04 trigger generator: LARGURA-cycle trigger pulse, then a bounded wait for the echo rising edge.
// Define GERADOR_TRIGGER_CONTINUO_EN for automatic re-triggering every INTERVALO cycles while gera is held.
module gerador_trigger_hcsr04 #(
    parameter int LARGURA   = 500,
    parameter int TIMEOUT   = 50000,
    parameter int INTERVALO = 3000000
) (
    input  logic                       clock,
    input  logic                       reset,
    gerador_trigger_hcsr04_if.slave    bus
);
    localparam int MAX_LT = (LARGURA > TIMEOUT) ? LARGURA : TIMEOUT;
    localparam int MAX_C  = (MAX_LT > INTERVALO) ? MAX_LT : INTERVALO;
    localparam int CW     = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] FIM_ENVIA   = CW'(LARGURA - 1);
    localparam logic [CW-1:0] FIM_ESPERA  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] UM          = CW'(1);
`ifdef GERADOR_TRIGGER_CONTINUO_EN
    localparam logic [CW-1:0] FIM_INTERVALO = CW'(INTERVALO - 1);
`endif

    typedef enum logic [2:0] {
        inicial     = 3'b000,
        envia       = 3'b010,
        espera_echo = 3'b011,
        fim_ok      = 3'b100,
        fim_timeout = 3'b101
`ifdef GERADOR_TRIGGER_CONTINUO_EN
        ,
        intervalo   = 3'b110
`endif
    } estado_t;

    estado_t       state_reg, state_next;
    logic [CW-1:0] contador_reg, contador_next;
    logic          echo_meta_reg, echo_s_reg, echo_s_d_reg;
    logic          gera_d_reg;
    logic          borda_echo, borda_gera;
    logic          estado_conta;

    assign borda_echo = echo_s_reg & ~echo_s_d_reg;
    assign borda_gera = bus.gera & ~gera_d_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= inicial;
            contador_reg  <= '0;
            echo_meta_reg <= 1'b0;
            echo_s_reg    <= 1'b0;
            echo_s_d_reg  <= 1'b0;
            gera_d_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            contador_reg  <= contador_next;
            echo_meta_reg <= bus.echo;
            echo_s_reg    <= echo_meta_reg;
            echo_s_d_reg  <= echo_s_reg;
            gera_d_reg    <= bus.gera;
        end
    end

    always_comb begin
        state_next   = state_reg;
        estado_conta = 1'b0;
        case (state_reg)
            inicial: begin
                if (borda_gera) state_next = envia;
            end
            envia: begin
                estado_conta = 1'b1;
                if (contador_reg == FIM_ENVIA) state_next = espera_echo;
            end
            espera_echo: begin
                estado_conta = 1'b1;
                // Echo edge takes priority over the window expiring in the same cycle.
                if (borda_echo)                     state_next = fim_ok;
                else if (contador_reg == FIM_ESPERA) state_next = fim_timeout;
            end
`ifdef GERADOR_TRIGGER_CONTINUO_EN
            fim_ok:      state_next = intervalo;
            fim_timeout: state_next = intervalo;
            intervalo: begin
                estado_conta = 1'b1;
                if (contador_reg == FIM_INTERVALO) state_next = bus.gera ? envia : inicial;
            end
`else
            fim_ok:      state_next = inicial;
            fim_timeout: state_next = inicial;
`endif
            default:     state_next = inicial;
        endcase

        // Each counting state starts from zero; leaving any state clears the count.
        if (state_next != state_reg) contador_next = '0;
        else if (estado_conta)       contador_next = contador_reg + UM;
        else                         contador_next = '0;
    end

    always_comb begin
        bus.trigger   = (state_reg == envia);
        bus.ocupado   = (state_reg != inicial);
        bus.pronto    = (state_reg == fim_ok);
        bus.timeout   = (state_reg == fim_timeout);
        bus.db_estado = state_reg;
    end
endmodule

// File: tb/tb_gerador_trigger_hcsr04.sv
// Directed bench for gerador_trigger_hcsr04 with a scoreboard of expected pronto/timeout pulses.
// Outputs are sampled 1 time unit after the rising clock edge.
module tb_gerador_trigger_hcsr04;
    localparam int LARGURA   = 5;
    localparam int TIMEOUT   = 20;
    localparam int INTERVALO = 10;

    logic clock = 1'b0;
    logic reset = 1'b1;

    gerador_trigger_hcsr04_if bus_if ();

    gerador_trigger_hcsr04 #(
        .LARGURA   (LARGURA),
        .TIMEOUT   (TIMEOUT),
        .INTERVALO (INTERVALO)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clock = ~clock;

    typedef struct {
        string tag;
        logic  eh_pronto;
        int    lat;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_trigger"}, bus_if.trigger, 0);
        chk({tag, "_ocupado"}, bus_if.ocupado, 0);
        chk({tag, "_pronto"},  bus_if.pronto, 0);
        chk({tag, "_timeout"}, bus_if.timeout, 0);
        chk({tag, "_db"},      bus_if.db_estado, 3'b000);
    endtask

    // Rising gera edge, then LARGURA trigger cycles; returns just after entering espera_echo.
    task automatic start_trigger(input string tag, input logic hold);
        bus_if.gera = 1'b0;
        step();
        bus_if.gera = 1'b1;
        step();
        if (!hold) bus_if.gera = 1'b0;
        for (int i = 0; i < LARGURA; i++) begin
            chk({tag, "_trig_hi"}, bus_if.trigger, 1);
            chk({tag, "_db_envia"}, bus_if.db_estado, 3'b010);
            if (i < LARGURA - 1) step();
        end
        step();
        chk({tag, "_trig_lo"}, bus_if.trigger, 0);
        chk({tag, "_db_espera"}, bus_if.db_estado, 3'b011);
    endtask

    // Handles the cycles following a result pulse; drop_idx lowers gera inside intervalo.
    task automatic after_pulse(input string tag, input int drop_idx);
        step();
`ifdef GERADOR_TRIGGER_CONTINUO_EN
        for (int i = 0; i < INTERVALO; i++) begin
            if (i == drop_idx) bus_if.gera = 1'b0;
            chk({tag, "_db_intervalo"}, bus_if.db_estado, 3'b110);
            chk({tag, "_ocup_intervalo"}, bus_if.ocupado, 1);
            chk({tag, "_trig_intervalo"}, bus_if.trigger, 0);
            if (i < INTERVALO - 1) step();
        end
        step();
        chk({tag, "_db_pos_intervalo"}, bus_if.db_estado, bus_if.gera ? 3'b010 : 3'b000);
        chk({tag, "_trig_pos_intervalo"}, bus_if.trigger, bus_if.gera);
`else
        if (drop_idx >= 0) bus_if.gera = 1'b0;
        chk_idle({tag, "_pos"});
`endif
    endtask

    task automatic wait_result(input int drop_idx);
        exp_t e;
        int   n = 0;
        do begin
            step();
            n++;
        end while (!(bus_if.pronto || bus_if.timeout) && n < 100);
        chk("sb_pending", exp_q.size(), 1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        chk({e.tag, "_pronto"},  bus_if.pronto,  e.eh_pronto);
        chk({e.tag, "_timeout"}, bus_if.timeout, !e.eh_pronto);
        chk({e.tag, "_latency"}, n, e.lat);
        chk({e.tag, "_db_fim"},  bus_if.db_estado, e.eh_pronto ? 3'b100 : 3'b101);
        chk({e.tag, "_ocupado"}, bus_if.ocupado, 1);
        $display("txn %s: %s after %0d cycles", e.tag, bus_if.pronto ? "pronto" : "timeout", n);
        bus_if.echo = 1'b0;
        after_pulse(e.tag, drop_idx);
    endtask

    initial begin
        bus_if.gera = 1'b0;
        bus_if.echo = 1'b0;

        // 1: power-on reset, then reset asserted mid-run
        repeat (3) step();
        chk_idle("reset_on");
        reset = 1'b0;
        repeat (3) step();
        chk_idle("reset_rel");
        start_trigger("t1", 1'b0);
        repeat (4) step();
        reset = 1'b1;
        #1;
        chk_idle("reset_mid");
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_idle("idle_no_gera");
        end

        // 2: echo rises 8 cycles after trigger falls -> pronto 2 cycles after sampling
        start_trigger("t2", 1'b0);
        repeat (7) step();
        bus_if.echo = 1'b1;
        exp_q.push_back('{tag: "t2_echo", eh_pronto: 1'b1, lat: 3});
        wait_result(-1);

        // 3: no echo -> timeout TIMEOUT cycles after entering espera_echo
        start_trigger("t3", 1'b0);
        exp_q.push_back('{tag: "t3_noecho", eh_pronto: 1'b0, lat: TIMEOUT});
        wait_result(-1);

        // 4a: echo already high before start gives no edge
        bus_if.echo = 1'b1;
        repeat (3) step();
        start_trigger("t4a", 1'b0);
        exp_q.push_back('{tag: "t4a_echo_alto", eh_pronto: 1'b0, lat: TIMEOUT});
        wait_result(-1);

        // 4b: edge seen on the last window cycle -> pronto wins
        bus_if.echo = 1'b0;
        repeat (3) step();
        start_trigger("t4b", 1'b0);
        repeat (TIMEOUT - 3) step();
        bus_if.echo = 1'b1;
        exp_q.push_back('{tag: "t4b_ultimo", eh_pronto: 1'b1, lat: 3});
        wait_result(-1);

        // 5: second gera edge during envia is ignored
        bus_if.gera = 1'b0;
        step();
        bus_if.gera = 1'b1;
        step();
        chk("t5_trig_c1", bus_if.trigger, 1);
        bus_if.gera = 1'b0;
        step();
        chk("t5_trig_c2", bus_if.trigger, 1);
        bus_if.gera = 1'b1;
        for (int i = 3; i <= LARGURA; i++) begin
            step();
            chk("t5_trig_cn", bus_if.trigger, 1);
        end
        bus_if.gera = 1'b0;
        step();
        chk("t5_trig_fim", bus_if.trigger, 0);
        chk("t5_db_espera", bus_if.db_estado, 3'b011);
        exp_q.push_back('{tag: "t5_ignorado", eh_pronto: 1'b0, lat: TIMEOUT});
        wait_result(-1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_idle("t5_sem_retrigger");
        end

        // 5b: reset on the third trigger cycle
        bus_if.gera = 1'b1;
        step();
        step();
        step();
        chk("t5b_trig_c3", bus_if.trigger, 1);
        reset = 1'b1;
        #1;
        chk_idle("t5b_reset");
        bus_if.gera = 1'b0;
        step();
        reset = 1'b0;
        step();
        chk_idle("t5b_pos_reset");

`ifdef GERADOR_TRIGGER_CONTINUO_EN
        // 6: gera held -> automatic re-trigger after intervalo, then drop gera inside intervalo
        start_trigger("t6", 1'b1);
        repeat (7) step();
        bus_if.echo = 1'b1;
        exp_q.push_back('{tag: "t6_cont", eh_pronto: 1'b1, lat: 3});
        wait_result(-1);
        for (int i = 1; i < LARGURA; i++) begin
            step();
            chk("t6_retrig", bus_if.trigger, 1);
        end
        step();
        chk("t6_retrig_fim", bus_if.trigger, 0);
        exp_q.push_back('{tag: "t6_drop", eh_pronto: 1'b0, lat: TIMEOUT});
        wait_result(4);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_idle("t6_sem_trigger");
        end
`endif

        chk("sb_vazio", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
